// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants and the nibble decoder used by the scan driver.
// Bit 6 is segment a, bit 0 is segment g; a 1 means the segment is lit.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_B    = 7'b0011111;
  localparam logic [6:0] SEG_C    = 7'b1001110;
  localparam logic [6:0] SEG_D    = 7'b0111101;
  localparam logic [6:0] SEG_E    = 7'b1001111;
  localparam logic [6:0] SEG_F    = 7'b1000111;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // In decimal mode the digits above 9 show a dash so that bad BCD is visible on the display.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = hex_en ? SEG_A : SEG_DASH;
      4'hB:    pattern = hex_en ? SEG_B : SEG_DASH;
      4'hC:    pattern = hex_en ? SEG_C : SEG_DASH;
      4'hD:    pattern = hex_en ? SEG_D : SEG_DASH;
      4'hE:    pattern = hex_en ? SEG_E : SEG_DASH;
      default: pattern = hex_en ? SEG_F : SEG_DASH;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_pattern.sv
// Combinational single-digit decoder: one nibble plus the mode bit in, segment pattern out.
// The pattern uses logical polarity, where a 1 means the segment is lit.
module seg7_hex_pattern (
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] pattern
);
  import seg7_pkg::*;

  assign pattern = nibble_to_seg(nibble, hex_en);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with a frame-aligned value update, leading-zero
// suppression, a global blank and selectable segment/anode polarity.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit ACTIVE_LOW_SEG = 1'b0,
  parameter bit ACTIVE_LOW_AN  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic                  load,
  input  logic                  hex_en,
  input  logic                  lz_suppress,
  input  logic                  blank,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_start,
  output logic                  update_pending
);
  import seg7_pkg::*;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VAL_W = 4 * N_DIGITS;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [VAL_W-1:0]    shadow;
  logic [VAL_W-1:0]    active;
  logic                pending;
  logic                tick;
  logic                wrap;
  logic [3:0]          nibble;
  logic [6:0]          pattern;
  logic                suppress;
  logic [N_DIGITS-1:0] an_next;
  logic [6:0]          seg_q;
  logic [N_DIGITS-1:0] an_q;
  logic                frame_q;

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IDX_W'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load in the wrap cycle bypasses the shadow, so it is shown in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= value_in;
      if (wrap) begin
        active  <= load ? value_in : shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble   = '0;
    an_next  = '0;
    suppress = lz_suppress;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nibble     = active[4*k +: 4];
        an_next[k] = 1'b1;
      end
      if ((IDX_W'(k) >= idx) && (active[4*k +: 4] != 4'h0)) suppress = 1'b0;
    end
    if (idx == '0) suppress = 1'b0;
    // Anodes stay dark in the first cycle of every slot so the previous digit cannot ghost.
    if (blank || (cnt == '0)) an_next = '0;
  end

  seg7_hex_pattern u_pattern (
    .nibble  (nibble),
    .hex_en  (hex_en),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= SEG_OFF;
      an_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= suppress ? SEG_OFF : pattern;
      an_q    <= an_next;
      frame_q <= wrap;
    end
  end

  assign seg_out        = seg_q ^ {7{ACTIVE_LOW_SEG}};
  assign an_out         = an_q ^ {N_DIGITS{ACTIVE_LOW_AN}};
  assign frame_start    = frame_q;
  assign update_pending = pending;

endmodule
